// File: rtl/axis_hdr_sched_pkg.sv
// Shared definitions for the header scheduler: state encoding and default sizing.
package axis_hdr_sched_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_N_REQ   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HDR  = 2'd1;
  localparam state_t ST_PKT  = 2'd2;

endpackage

// File: rtl/axis_hdr_sched_rr_arbiter.sv
// Combinational round-robin selector: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int N      = 4,
  parameter int IDX_WD = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [IDX_WD-1:0] ptr,
  output logic [N-1:0]      gnt,
  output logic [IDX_WD-1:0] idx
);

  logic              found;
  logic [IDX_WD:0]   sum;
  logic [IDX_WD-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_WD+1)'(k);
      if (sum >= (IDX_WD+1)'(N)) sum = sum - (IDX_WD+1)'(N);
      cand = sum[IDX_WD-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/axis_hdr_sched.sv
// Header scheduler: round-robin grants one requester at a time, presents its latched
// header to the inserter, then owns the grant until the packet's last beat completes.
module axis_hdr_sched
  import axis_hdr_sched_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_REQ        = DEF_N_REQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*DATA_WD-1:0]       req_data,
  input  logic [N_REQ*DATA_BYTE_WD-1:0]  req_keep,
  input  logic [N_REQ*BYTE_CNT_WD-1:0]   req_byte_cnt,
  output logic [N_REQ-1:0]               req_ready,
  output logic                           valid_insert,
  output logic [DATA_WD-1:0]             data_insert,
  output logic [DATA_BYTE_WD-1:0]        keep_insert,
  output logic [BYTE_CNT_WD-1:0]         byte_insert_cnt,
  input  logic                           ready_insert,
  input  logic                           valid_out,
  input  logic                           ready_out,
  input  logic                           last_out,
  output logic [$clog2(N_REQ)-1:0]       grant_idx,
  output logic                           busy,
  output logic [15:0]                    pkt_cnt
);

  localparam int IDX_WD = $clog2(N_REQ);

  state_t                   state;
  logic [IDX_WD-1:0]        rr_ptr;
  logic [N_REQ-1:0]         arb_gnt;
  logic [IDX_WD-1:0]        arb_idx;
  logic [DATA_WD-1:0]       sel_data;
  logic [DATA_BYTE_WD-1:0]  sel_keep;
  logic [BYTE_CNT_WD-1:0]   sel_cnt;
  logic                     hdr_acc;
  logic                     last_hs;
  logic [IDX_WD-1:0]        next_ptr;

  rr_arbiter #(.N(N_REQ), .IDX_WD(IDX_WD)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_cnt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_data[i*DATA_WD +: DATA_WD];
        sel_keep = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_cnt  = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
      end
    end
  end

  assign hdr_acc  = (state == ST_HDR) && ready_insert;
  assign last_hs  = valid_out && ready_out && last_out;
  assign next_ptr = (grant_idx == IDX_WD'(N_REQ-1)) ? '0 : grant_idx + IDX_WD'(1);

  // Gated by rst so outputs read as idle throughout the reset cycle, not only after it.
  assign valid_insert = !rst && (state == ST_HDR);
  assign busy         = !rst && (state != ST_IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = !rst && hdr_acc && (grant_idx == IDX_WD'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      pkt_cnt         <= '0;
      data_insert     <= '0;
      keep_insert     <= '0;
      byte_insert_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && (|req_valid)) begin
            grant_idx       <= arb_idx;
            data_insert     <= sel_data;
            keep_insert     <= sel_keep;
            byte_insert_cnt <= sel_cnt;
            state           <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (ready_insert) begin
            // Header accept coinciding with a last beat closes a single-beat packet.
            if (last_hs) begin
              state   <= ST_IDLE;
              pkt_cnt <= pkt_cnt + 16'd1;
              rr_ptr  <= next_ptr;
            end else begin
              state <= ST_PKT;
            end
          end
        end
        ST_PKT: begin
          if (last_hs) begin
            state   <= ST_IDLE;
            pkt_cnt <= pkt_cnt + 16'd1;
            rr_ptr  <= next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_hdr_sched.sv
// Directed self-checking bench for axis_hdr_sched (4 requesters, 32-bit headers).
module tb_axis_hdr_sched;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR*BW-1:0] req_keep;
  logic [NR*CW-1:0] req_byte_cnt;
  logic [NR-1:0]   req_ready;
  logic            valid_insert;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            ready_insert;
  logic            valid_out, ready_out, last_out;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [15:0]     pkt_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_hdr_sched dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
    .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt),
    .ready_insert(ready_insert), .valid_out(valid_out), .ready_out(ready_out),
    .last_out(last_out), .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0; req_keep = '0;
    req_byte_cnt = '0; ready_insert = 1'b0;
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
    tick(); tick();
    chk("rst_valid_insert", valid_insert, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_data_insert", data_insert, 0);
    chk("rst_keep_insert", keep_insert, 0);
    chk("rst_byte_cnt", byte_insert_cnt, 0);
    rst = 1'b0;

    // Single request from requester 0
    en = 1'b1; ready_insert = 1'b1;
    req_valid = 4'b0001;
    req_data[0*DW +: DW] = 32'hA5A5A5A5;
    req_keep[0*BW +: BW] = 4'hF;
    req_byte_cnt[0*CW +: CW] = 2'd1;
    #1;
    chk("single_idle_valid", valid_insert, 0);
    chk("single_idle_ready", req_ready, 0);
    tick();
    chk("single_hdr_valid", valid_insert, 1);
    chk("single_hdr_data", data_insert, 32'hA5A5A5A5);
    chk("single_hdr_keep", keep_insert, 4'hF);
    chk("single_hdr_cnt", byte_insert_cnt, 1);
    chk("single_hdr_ready", req_ready, 4'b0001);
    chk("single_hdr_busy", busy, 1);
    req_valid = 4'b0000;
    req_data[0*DW +: DW] = 32'h0;
    #1;
    chk("single_latched_data", data_insert, 32'hA5A5A5A5);
    tick();
    chk("single_pkt_valid", valid_insert, 0);
    chk("single_pkt_ready", req_ready, 0);
    chk("single_pkt_busy", busy, 1);
    valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b0;
    tick();
    chk("single_pkt_mid_busy", busy, 1);
    last_out = 1'b1;
    tick();
    chk("single_done_busy", busy, 0);
    chk("single_done_pkt_cnt", pkt_cnt, 1);
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;

    // Reset asserted mid-packet (rr_ptr is 1 at this point)
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("rstpkt_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstpkt_busy_during", busy, 0);
    chk("rstpkt_valid_during", valid_insert, 0);
    chk("rstpkt_ready_during", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstpkt_pkt_cnt", pkt_cnt, 0);
    chk("rstpkt_grant_idx", grant_idx, 0);
    chk("rstpkt_data", data_insert, 0);
    chk("rstpkt_busy_after", busy, 0);

    // Fairness with single-beat packets; rr_ptr=0 after reset so order starts at 0
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = 32'h1111_0000 + 32'(i);
      req_keep[i*BW +: BW] = 4'hF;
      req_byte_cnt[i*CW +: CW] = 2'(i);
    end
    req_valid = 4'b1111; ready_insert = 1'b1;
    valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fair_idle_busy", busy, 0);
      tick();
      chk("fair_grant_idx", grant_idx, k % 4);
      chk("fair_req_ready", req_ready, 4'b0001 << (k % 4));
      chk("fair_data", data_insert, 32'h1111_0000 + 32'(k % 4));
      tick();
    end
    chk("fair_pkt_cnt", pkt_cnt, 5);
    chk("fair_end_busy", busy, 0);
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;

    // Insert backpressure on requester 2
    req_valid = 4'b0100; ready_insert = 1'b0;
    tick();
    req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      chk("ibp_valid", valid_insert, 1);
      chk("ibp_data", data_insert, 32'h1111_0002);
      chk("ibp_ready", req_ready, 0);
      tick();
    end
    ready_insert = 1'b1;
    #1;
    chk("ibp_release_ready", req_ready, 4'b0100);
    chk("ibp_grant_idx", grant_idx, 2);
    tick();
    chk("ibp_after_ready", req_ready, 0);
    chk("ibp_after_valid", valid_insert, 0);
    ready_insert = 1'b0;

    // Output backpressure holds PKT
    valid_out = 1'b1; last_out = 1'b1; ready_out = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("obp_busy_hold", busy, 1);
    end
    ready_out = 1'b1;
    tick();
    chk("obp_idle_busy", busy, 0);
    chk("obp_pkt_cnt", pkt_cnt, 6);
    valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;

    // en=0 blocks arbitration
    en = 1'b0; req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en0_busy", busy, 0);
      chk("en0_valid", valid_insert, 0);
    end
    en = 1'b1;
    tick();
    chk("en1_grant_idx", grant_idx, 1);
    chk("en1_valid", valid_insert, 1);
    chk("en1_data", data_insert, 32'h1111_0001);
    ready_insert = 1'b1; valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("en1_req_ready", req_ready, 4'b0010);
    tick();
    chk("en1_done_busy", busy, 0);
    chk("en1_pkt_cnt", pkt_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
